exec_cycle_sequencer: RTL

EXEC_CYCLE_SEQUENCER -- requirements
Module: exec_cycle_sequencer

---
 rtl/exec_cycle_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/exec_cycle_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> WRITEBACK.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes lock the FSM in TRAP until reset.
module exec_cycle_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic        imem_rdy,
  input  logic [7:0]  imem_data,
  output logic        imem_req,
  output logic [7:0]  pc,
  output logic [7:0]  ir,
  output logic        alu_en,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        busy,
  output logic        trap,
  output logic [15:0] retired_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [15:0] retired_q, retired_d;
  logic        wb_q, wb_d;
  logic        alu_src_q, alu_src_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic        imem_req_q, alu_en_q, reg_write_q, busy_q;
  logic        retire;
  logic        dec_src, dec_wb;
  logic [1:0]  dec_op;

  always_comb begin
    dec_src = 1'b0;
    dec_op  = 2'b00;
    dec_wb  = 1'b0;
    case (ir_q[7:5])
      3'b001: dec_wb = 1'b1;
      3'b010: begin dec_src = 1'b1; dec_wb = 1'b1; end
      3'b011: begin dec_op = 2'b01; dec_wb = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    wb_d      = wb_q;
    alu_src_d = alu_src_q;
    alu_op_d  = alu_op_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_rdy) begin
          ir_d    = imem_data;
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_d = dec_src;
        alu_op_d  = dec_op;
        wb_d      = dec_wb;
        state_d   = S_EXECUTE;
`ifdef ILLEGAL_TRAP_EN
        if (ir_q[7]) state_d = S_TRAP;
`endif
      end
      S_EXECUTE: begin
        if (wb_q) begin
          state_d = S_WRITEBACK;
        end else begin
          retire  = 1'b1;
          state_d = halt_req ? S_IDLE : S_FETCH;
        end
      end
      S_WRITEBACK: begin
        retire  = 1'b1;
        state_d = halt_req ? S_IDLE : S_FETCH;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // ALU controls are only visible while the instruction is in EXECUTE/WRITEBACK
    if (state_d != S_EXECUTE && state_d != S_WRITEBACK) begin
      alu_src_d = 1'b0;
      alu_op_d  = 2'b00;
    end
    retired_d = (retire && retired_q != 16'hFFFF) ? retired_q + 16'd1 : retired_q;
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= 8'd0;
      ir_q        <= 8'd0;
      retired_q   <= 16'd0;
      wb_q        <= 1'b0;
      alu_src_q   <= 1'b0;
      alu_op_q    <= 2'b00;
      imem_req_q  <= 1'b0;
      alu_en_q    <= 1'b0;
      reg_write_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      retired_q   <= retired_d;
      wb_q        <= wb_d;
      alu_src_q   <= alu_src_d;
      alu_op_q    <= alu_op_d;
      imem_req_q  <= (state_d == S_FETCH);
      alu_en_q    <= (state_d == S_EXECUTE);
      reg_write_q <= (state_d == S_WRITEBACK);
      busy_q      <= (state_d == S_FETCH) || (state_d == S_DECODE) ||
                     (state_d == S_EXECUTE) || (state_d == S_WRITEBACK);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= (state_d == S_TRAP);
  end
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  assign imem_req    = imem_req_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign alu_en      = alu_en_q;
  assign alu_src     = alu_src_q;
  assign alu_op      = alu_op_q;
  assign reg_write   = reg_write_q;
  assign busy        = busy_q;
  assign retired_cnt = retired_q;
  assign state       = state_q;

endmodule
